// File: rtl/ab_opt_acc.sv
// ab_opt_acc: batch accumulator placed downstream of the ab_opt arithmetic stage.
// Latency: res_valid rises the cycle after the LEN-th accepted sample.
// Backpressure: in_ready is high only in ACC; the result is held in HOLD until res_ready.
//
// Ports:
//   clk, rst (async, active high)      : clock and reset
//   start, abort                       : begin a batch (IDLE only) / return to IDLE from anywhere
//   op_sel, aplusb, aminusb, amultb    : operand select and the three ab_opt results
//   in_valid / in_ready                : sample handshake
//   res_data, res_valid / res_ready    : signed batch total handshake
//   ovf, err, busy                     : sticky overflow, sticky illegal select, not-IDLE
//
// Optional build macro AB_ACC_SAT_EN: when defined the accumulator saturates on
// signed overflow instead of wrapping modulo 2^ACC_W.
module ab_opt_acc #(
    parameter int LEN   = 4,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       op_sel,
    input  logic [4:0]       aplusb,
    input  logic [4:0]       aminusb,
    input  logic [7:0]       amultb,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             ovf,
    output logic             err,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [7:0] LP_LAST = 8'(LEN - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [7:0]       r_cnt;
    logic [ACC_W-1:0] r_res;
    logic             r_ovf;
    logic             r_err;

    logic [ACC_W-1:0] w_operand;
    logic             w_illegal;
    logic [ACC_W-1:0] w_sum;
    logic             w_ovf_add;
    logic [ACC_W-1:0] w_acc_nxt;
    logic             w_xfer;
    logic             w_last;

    // Operand extension: sum and product are unsigned, difference is 5-bit signed.
    always_comb begin
        w_operand = '0;
        w_illegal = 1'b0;
        case (op_sel)
            2'b00:   w_operand = {{(ACC_W-5){1'b0}}, aplusb};
            2'b01:   w_operand = {{(ACC_W-5){aminusb[4]}}, aminusb};
            2'b10:   w_operand = {{(ACC_W-8){1'b0}}, amultb};
            default: w_illegal = 1'b1;  // counts as a sample contributing zero
        endcase
    end

    assign w_sum = r_acc + w_operand;

    // Signed overflow: both addends share a sign and the result's sign differs.
    assign w_ovf_add = (r_acc[ACC_W-1] == w_operand[ACC_W-1]) &&
                       (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

`ifdef AB_ACC_SAT_EN
    // Clamp toward the operand's sign; later samples continue from the clamp.
    always_comb begin
        w_acc_nxt = w_sum;
        if (w_ovf_add) begin
            w_acc_nxt = w_operand[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                           : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign w_acc_nxt = w_sum;
`endif

    assign w_xfer = (r_state == ST_ACC) && in_valid;
    assign w_last = (r_cnt == LP_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Outputs decode the current state; abort only overrides the next state,
    // so res_valid drops on the following cycle.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_ACC;
            end
            ST_ACC: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_xfer && w_last) w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                res_valid = 1'b1;
                busy      = 1'b1;
                if (res_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (abort) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_res <= '0;
            r_ovf <= 1'b0;
            r_err <= 1'b0;
        end else if (abort) begin
            // A sample offered in the same cycle is dropped; r_res keeps the last total.
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_err <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (start) begin
                r_acc <= '0;
                r_cnt <= '0;
                r_ovf <= 1'b0;
                r_err <= 1'b0;
            end
        end else if (w_xfer) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + 8'd1;
            r_ovf <= r_ovf | w_ovf_add;
            r_err <= r_err | w_illegal;
            // Capture the final total so it stays stable through HOLD and IDLE.
            if (w_last) r_res <= w_acc_nxt;
        end
    end

    assign res_data = r_res;
    assign ovf      = r_ovf;
    assign err      = r_err;

endmodule

// File: tb/tb_ab_opt_acc.sv
`timescale 1ns/1ps
module tb_ab_opt_acc;

    localparam int LEN   = 4;
    localparam int ACC_W = 9;
    localparam int MAXV  = 2**(ACC_W-1) - 1;
    localparam int MINV  = -(2**(ACC_W-1));

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [1:0]       op_sel;
    logic [4:0]       aplusb;
    logic [4:0]       aminusb;
    logic [7:0]       amultb;
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] res_data;
    logic             res_valid;
    logic             res_ready;
    logic             ovf;
    logic             err;
    logic             busy;

    always #5 clk = ~clk;

    ab_opt_acc #(.LEN(LEN), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .op_sel(op_sel), .aplusb(aplusb), .aminusb(aminusb), .amultb(amultb),
        .in_valid(in_valid), .in_ready(in_ready),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .ovf(ovf), .err(err), .busy(busy)
    );

    typedef struct {
        logic [ACC_W-1:0] data;
        logic             ovf;
        logic             err;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   ok;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ab(input int a, input int b, input logic [1:0] sel);
        aplusb  = 5'(a + b);
        aminusb = 5'(a - b);
        amultb  = 8'(a * b);
        op_sel  = sel;
    endtask

    // Offer one sample and wait (bounded) until it is accepted.
    task automatic send(input int a, input int b, input logic [1:0] sel);
        bit done;
        done = 1'b0;
        set_ab(a, b, sel);
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (in_ready) done = 1'b1;
            tick();
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout in_ready=%0b required 1", in_ready);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_res(output bit got);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (res_valid) got = 1'b1;
            else tick();
        end
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    function automatic int opval(input int a, input int b, input logic [1:0] sel);
        int d;
        case (sel)
            2'b00:   return (a + b) & 31;
            2'b01:   begin d = (a - b) & 31; return (d >= 16) ? d - 32 : d; end
            2'b10:   return (a * b) & 255;
            default: return 0;
        endcase
    endfunction

    task automatic model_add(inout int acc, inout bit o, input int op);
        int s;
        s = acc + op;
        if (s > MAXV || s < MINV) begin
            o = 1'b1;
`ifdef AB_ACC_SAT_EN
            s = (op < 0) ? MINV : MAXV;
`else
            s = s & (2**ACC_W - 1);
            if (s > MAXV) s = s - 2**ACC_W;
`endif
        end
        acc = s;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; op_sel = 2'b00;
        aplusb = '0; aminusb = '0; amultb = '0; in_valid = 1'b0; res_ready = 1'b0;
        #12;
        n_checks++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_in_ready got %0b want 0", in_ready); end
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_res_valid got %0b want 0", res_valid); end
        n_checks++; if (res_data !== '0)    begin n_fail++; $display("FAIL rst_res_data got %0d want 0", res_data); end
        n_checks++; if ({ovf, err, busy} !== 3'b000) begin n_fail++; $display("FAIL rst_flags got %b want 000", {ovf, err, busy}); end
        rst = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy got %0b want 0", busy); end
    endtask

    task automatic test_product();
        do_start();
        n_checks++; if ({busy, in_ready} !== 2'b11) begin n_fail++; $display("FAIL prod_acc_state got %b want 11", {busy, in_ready}); end
        sb.push_back('{data: 9'd134, ovf: 1'b0, err: 1'b0});
        send(11, 7, 2'b10); send(6, 5, 2'b10); send(15, 1, 2'b10); send(3, 4, 2'b10);
        in_valid = 1'b0;
        // Result must already be valid one cycle after the 4th transfer.
        n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL prod_latency res_valid got %0b want 1", res_valid); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL prod_hold_in_ready got %0b want 0", in_ready); end
        e = sb.pop_front();
        n_checks++; if (res_data !== e.data) begin n_fail++; $display("FAIL prod_data got %0d want %0d", $signed(res_data), $signed(e.data)); end
        n_checks++; if ({ovf, err} !== {e.ovf, e.err}) begin n_fail++; $display("FAIL prod_flags got %b want %b", {ovf, err}, {e.ovf, e.err}); end
        handshake();
        n_checks++; if ({busy, res_valid} !== 2'b00) begin n_fail++; $display("FAIL prod_idle got %b want 00", {busy, res_valid}); end
    endtask

    task automatic test_difference();
        do_start();
        sb.push_back('{data: 9'd18, ovf: 1'b0, err: 1'b0});
        send(11, 7, 2'b01); send(6, 5, 2'b01); send(15, 1, 2'b01); send(3, 4, 2'b01);
        in_valid = 1'b0;
        wait_res(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL diff_res_valid timeout got 0 want 1"); end
        e = sb.pop_front();
        n_checks++; if (res_data !== e.data) begin n_fail++; $display("FAIL diff_data got %0d want %0d", $signed(res_data), $signed(e.data)); end
        n_checks++; if ({ovf, err} !== {e.ovf, e.err}) begin n_fail++; $display("FAIL diff_flags got %b want %b", {ovf, err}, {e.ovf, e.err}); end
        handshake();
    endtask

    task automatic test_backpressure();
        int a_t[4] = '{11, 6, 15, 3};
        int b_t[4] = '{7, 5, 1, 4};
        do_start();
        sb.push_back('{data: 9'd52, ovf: 1'b0, err: 1'b0});
        for (int i = 0; i < 4; i++) begin
            send(a_t[i], b_t[i], 2'b00);
            in_valid = 1'b0;
            if (i < 3) tick();
        end
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid cyc%0d got %0b want 1", i, res_valid); end
            n_checks++; if (res_data !== e.data) begin n_fail++; $display("FAIL stall_data cyc%0d got %0d want %0d", i, $signed(res_data), $signed(e.data)); end
            tick();
        end
        handshake();
        n_checks++; if ({busy, res_valid} !== 2'b00) begin n_fail++; $display("FAIL stall_idle got %b want 00", {busy, res_valid}); end
        n_checks++; if (res_data !== e.data) begin n_fail++; $display("FAIL idle_keep_data got %0d want %0d", $signed(res_data), $signed(e.data)); end
    endtask

    task automatic test_overflow();
        do_start();
`ifdef AB_ACC_SAT_EN
        sb.push_back('{data: 9'd255, ovf: 1'b1, err: 1'b0});
`else
        sb.push_back('{data: 9'(-124), ovf: 1'b1, err: 1'b0});
`endif
        for (int i = 0; i < 4; i++) send(15, 15, 2'b10);
        in_valid = 1'b0;
        wait_res(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL ovf_res_valid timeout got 0 want 1"); end
        e = sb.pop_front();
        n_checks++; if (res_data !== e.data) begin n_fail++; $display("FAIL ovf_data got %0d want %0d", $signed(res_data), $signed(e.data)); end
        n_checks++; if ({ovf, err} !== {e.ovf, e.err}) begin n_fail++; $display("FAIL ovf_flags got %b want %b", {ovf, err}, {e.ovf, e.err}); end
        handshake();
    endtask

    task automatic test_abort_illegal();
        do_start();
        sb.push_back('{data: 9'd104, ovf: 1'b0, err: 1'b1});
        send(11, 7, 2'b10);
        send(6, 5, 2'b11);
        start = 1'b1;              // must be ignored outside IDLE
        send(15, 1, 2'b10);
        start = 1'b0;
        send(3, 4, 2'b10);
        in_valid = 1'b0;
        wait_res(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL ill_res_valid timeout got 0 want 1"); end
        e = sb.pop_front();
        n_checks++; if (res_data !== e.data) begin n_fail++; $display("FAIL ill_data got %0d want %0d", $signed(res_data), $signed(e.data)); end
        n_checks++; if ({ovf, err} !== {e.ovf, e.err}) begin n_fail++; $display("FAIL ill_flags got %b want %b", {ovf, err}, {e.ovf, e.err}); end
        handshake();

        do_start();
        send(15, 15, 2'b10);
        send(15, 15, 2'b10);
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL abort_pre_ovf got %0b want 1", ovf); end
        set_ab(15, 15, 2'b11);
        in_valid = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        in_valid = 1'b0;
        n_checks++; if ({busy, in_ready, res_valid} !== 3'b000) begin n_fail++; $display("FAIL abort_idle got %b want 000", {busy, in_ready, res_valid}); end
        n_checks++; if ({ovf, err} !== 2'b00) begin n_fail++; $display("FAIL abort_flags got %b want 00", {ovf, err}); end
        ok = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (res_valid) ok = 1'b1;
            tick();
        end
        n_checks++; if (ok) begin n_fail++; $display("FAIL abort_no_result res_valid got 1 want 0"); end
    endtask

    task automatic test_async_reset();
        do_start();
        send(11, 7, 2'b00);
        send(6, 5, 2'b00);
        in_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        n_checks++; if ({busy, in_ready, res_valid, ovf, err} !== 5'b00000) begin n_fail++; $display("FAIL arst_flags got %b want 00000", {busy, in_ready, res_valid, ovf, err}); end
        n_checks++; if (res_data !== '0) begin n_fail++; $display("FAIL arst_data got %0d want 0", res_data); end
        #2 rst = 1'b0;
        tick();
        do_start();
        sb.push_back('{data: 9'd52, ovf: 1'b0, err: 1'b0});
        send(11, 7, 2'b00); send(6, 5, 2'b00); send(15, 1, 2'b00); send(3, 4, 2'b00);
        in_valid = 1'b0;
        wait_res(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL arst_res_valid timeout got 0 want 1"); end
        e = sb.pop_front();
        n_checks++; if (res_data !== e.data) begin n_fail++; $display("FAIL arst_clean_data got %0d want %0d", $signed(res_data), $signed(e.data)); end
        handshake();
    endtask

    task automatic test_back_to_back();
        int acc;
        bit o, er;
        int a, b;
        logic [1:0] sel;
        for (int n = 0; n < 4; n++) begin
            do_start();   // issued the cycle right after the previous handshake
            acc = 0; o = 1'b0; er = 1'b0;
            for (int i = 0; i < LEN; i++) begin
                a   = int'($urandom_range(0, 15));
                b   = int'($urandom_range(0, 15));
                sel = 2'($urandom_range(0, 3));
                if (sel == 2'b11) er = 1'b1;
                model_add(acc, o, opval(a, b, sel));
                send(a, b, sel);
                if ($urandom_range(0, 1) == 1) begin in_valid = 1'b0; tick(); end
            end
            in_valid = 1'b0;
            sb.push_back('{data: ACC_W'(acc), ovf: o, err: er});
            wait_res(ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b%0d_res_valid timeout got 0 want 1", n); end
            e = sb.pop_front();
            n_checks++; if (res_data !== e.data) begin n_fail++; $display("FAIL b2b%0d_data got %0d want %0d", n, $signed(res_data), $signed(e.data)); end
            n_checks++; if ({ovf, err} !== {e.ovf, e.err}) begin n_fail++; $display("FAIL b2b%0d_flags got %b want %b", n, {ovf, err}, {e.ovf, e.err}); end
            handshake();
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b%0d_idle busy got %0b want 0", n, busy); end
        end
    endtask

    initial begin
        test_reset();
        test_product();
        test_difference();
        test_backpressure();
        test_overflow();
        test_abort_illegal();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ab_opt_acc.md
Name: ab_opt_acc

Overview:
Sequential consumer placed directly downstream of ab_opt. Takes ab_opt's three combinational results (AplusB, AminusB, AmultB) through a valid/ready handshake and selects one of them per sample. It accumulates LEN selected samples into a signed register. It then presents the total on a result handshake, giving the combinational arithmetic stage a batch dot-product/sum capability.

Parameters:
- LEN, 4: samples per batch; legal range 1..255.
- ACC_W, 16: accumulator/result width in bits; minimum 9.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: begin batch; sampled only in IDLE.
- abort, input, 1: synchronous abort; returns to IDLE from any state.
- op_sel, input, 2: operand select, sampled with each accepted sample. 00=AplusB, 01=AminusB, 10=AmultB, 11=illegal.
- aplusb, input, 5: ab_opt sum, unsigned.
- aminusb, input, 5: ab_opt difference, 5-bit two's complement.
- amultb, input, 8: ab_opt product, unsigned.
- in_valid, input, 1: upstream sample valid.
- in_ready, output, 1: block accepts a sample this cycle.
- res_data, output, ACC_W: signed batch total.
- res_valid, output, 1: res_data valid.
- res_ready, input, 1: downstream accepts result.
- ovf, output, 1: accumulator overflowed in this batch; sticky.
- err, output, 1: illegal op_sel seen in this batch; sticky.
- busy, output, 1: state is not IDLE.

Behaviour:
- Reset: state=IDLE; acc, cnt, res_data all zero; in_ready, res_valid, ovf, err, busy all 0.
- States are IDLE, ACC and HOLD.
- IDLE:
  - in_ready=0, res_valid=0.
  - On start=1: acc<=0, cnt<=0, ovf<=0, err<=0, next state ACC.
- ACC:
  - in_ready=1.
  - A transfer occurs when in_valid & in_ready.
  - On transfer: acc<=acc+operand and cnt<=cnt+1.
  - On transfer with cnt==LEN-1: next state HOLD.
  - With no transfer, acc and cnt hold their values.
- Operand extension to ACC_W:
  - aplusb and amultb: zero-extended.
  - aminusb: sign-extended from bit 4 (11111 = -1).
  - op_sel=11: operand is 0, sample still counts, err<=1.
- HOLD:
  - in_ready=0, res_valid=1, res_data=acc, held stable until res_ready.
  - On res_valid & res_ready: next state IDLE; res_valid is 0 the following cycle.
  - res_data keeps its last value in IDLE.
- Latency: res_valid asserts on the cycle after the LEN-th transfer.
- Back-to-back batches: start asserted in the cycle after the HOLD handshake is accepted (IDLE). Minimum gap between batches is 1 cycle.
- start outside IDLE: ignored.
- abort (highest priority after rst):
  - Next state IDLE; acc and cnt cleared; ovf and err cleared.
  - res_valid drops next cycle; any in-flight transfer that same cycle is discarded.
- Overflow rule: signed two's-complement overflow of the ACC_W addition sets ovf. ovf stays set until the next start or abort.
- rst mid-batch: immediate return to reset values, regardless of clock.
- busy=1 in ACC and HOLD.

Optional Feature:
- Macro AB_ACC_SAT_EN.
- Defined: on overflow, acc clamps to +(2^(ACC_W-1)-1) or -(2^(ACC_W-1)) according to the operand's sign. Later samples continue accumulating from the clamped value.
- Undefined: acc wraps modulo 2^ACC_W.
- ovf behaviour is identical in both builds.

Test Plan:
- Product batch. LEN=4, op_sel=10, in_valid held high. A/B pairs are 11/7, 6/5, 15/1, 3/4, giving amultb = 77, 30, 15, 12. Expected: res_valid 1 cycle after 4th transfer, res_data=134, ovf=0, err=0.
- Difference batch. Same pairs with op_sel=01, giving aminusb = 00100, 00001, 01110, 11111. Expected: res_data=18. The -1 sample confirms sign extension.
- Backpressure and gaps. Sum batch (aplusb = 18, 11, 16, 7) with in_valid deasserted on alternate cycles, then res_ready held low 5 cycles. Expected: res_data=52 stable and res_valid high throughout the stall; IDLE the cycle after res_ready.
- Overflow. ACC_W=9, LEN=4, amultb=225 (15*15) every sample.
  - AB_ACC_SAT_EN defined: res_data=255, ovf=1.
  - AB_ACC_SAT_EN undefined: 900 mod 512 = 388, read as signed gives res_data=-124, ovf=1.
- Abort and illegal select.
  - op_sel=11 on sample 2 of a 4-sample batch: err=1 at HOLD, and that sample contributes 0.
  - New batch aborted after 2 transfers: IDLE next cycle, ovf=0, err=0, no res_valid.
  - start ignored while in ACC.
- Async reset. rst asserted mid-batch between clock edges. Expected: all outputs 0 immediately; start after release begins a clean batch with correct total.
